collision_pair_scheduler: RTL and testbench

// Once per frame, sweeps all ball pairs and issues a resolve request for each colliding, armed pair.

---
 rtl/collision_pair_scheduler_pkg.sv | 17 +
 rtl/collision_pair_scheduler_if.sv | 33 +++
 rtl/collision_pair_scheduler_pair_index_counter.sv | 43 ++++
 rtl/collision_pair_scheduler.sv | 131 +++++++++++++
 tb/tb_collision_pair_scheduler.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/collision_pair_scheduler_pkg.sv
// Shared constants and state encoding for the per-frame collision pair scheduler.
// Pure declarations: no timing, no flow control.
package collision_pair_scheduler_pkg;

  localparam int NUM_BALLS   = 16;
  localparam int IDX_W       = $clog2(NUM_BALLS);
  localparam int NUM_PAIRS   = NUM_BALLS * (NUM_BALLS - 1) / 2;
  localparam int ACK_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/collision_pair_scheduler_if.sv
// Hit-matrix input, resolver handshake and status outputs of the pair scheduler.
// master = scheduler side, slave = frame source / resolver side.
interface collision_pair_scheduler_if #(
  parameter int NUM_BALLS = collision_pair_scheduler_pkg::NUM_BALLS
);
  localparam int NUM_PAIRS = NUM_BALLS * (NUM_BALLS - 1) / 2;
  localparam int IDX_W     = $clog2(NUM_BALLS);

  logic                 frameStart;
  logic [NUM_PAIRS-1:0] hitPairs;
  logic                 resolveReq;
  logic [IDX_W-1:0]     resolveIdxA;
  logic [IDX_W-1:0]     resolveIdxB;
  logic                 resolveAck;
  logic                 busy;
  logic                 collisionOccurred;
  logic [7:0]           collisionCount;
  logic                 sweepOverrun;
  logic                 resolveTimeout;

  modport master (
    input  frameStart, hitPairs, resolveAck,
    output resolveReq, resolveIdxA, resolveIdxB, busy,
           collisionOccurred, collisionCount, sweepOverrun, resolveTimeout
  );

  modport slave (
    output frameStart, hitPairs, resolveAck,
    input  resolveReq, resolveIdxA, resolveIdxB, busy,
           collisionOccurred, collisionCount, sweepOverrun, resolveTimeout
  );

endinterface

// File: rtl/collision_pair_scheduler_pair_index_counter.sv
// Walks (a,b) pairs lexicographically with a<b and a linear pair number p; one pair per step.
// Outputs are registered; last flags the final pair (N-2,N-1).
module pair_index_counter #(
  parameter int NUM_BALLS = 16,
  parameter int IDX_W     = 4,
  parameter int P_W       = 7
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             clear,
  input  logic             step,
  output logic [IDX_W-1:0] a,
  output logic [IDX_W-1:0] b,
  output logic [P_W-1:0]   p,
  output logic             last
);

  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(NUM_BALLS - 1);

  assign last = (b == MAX_IDX) && (a == MAX_IDX - IDX_W'(1));

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      a <= '0;
      b <= IDX_W'(1);
      p <= '0;
    end else if (clear) begin
      a <= '0;
      b <= IDX_W'(1);
      p <= '0;
    end else if (step) begin
      p <= p + P_W'(1);
      // Row exhausted: the next row starts just above the new a.
      if (b == MAX_IDX) begin
        a <= a + IDX_W'(1);
        b <= a + IDX_W'(2);
      end else begin
        b <= b + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/collision_pair_scheduler.sv
// Per-frame sweep of all ball pairs, serialising resolve requests for armed, touching pairs.
// Scan costs 1 cycle/pair; a pending pair holds resolveReq until ack or ACK_TIMEOUT.
module collision_pair_scheduler #(
  parameter int NUM_BALLS   = collision_pair_scheduler_pkg::NUM_BALLS,
  parameter int ACK_TIMEOUT = collision_pair_scheduler_pkg::ACK_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       resetN,
  collision_pair_scheduler_if.master bus
);
  import collision_pair_scheduler_pkg::*;

  localparam int NUM_PAIRS = NUM_BALLS * (NUM_BALLS - 1) / 2;
  localparam int IDX_W     = $clog2(NUM_BALLS);
  localparam int P_W       = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
  localparam int WAIT_W    = $clog2(ACK_TIMEOUT + 1);

  sched_state_t         state, state_nxt;
  logic [NUM_PAIRS-1:0] armed, pending;
  logic [WAIT_W-1:0]    wait_cnt;
  logic [7:0]           count;
  logic [IDX_W-1:0]     idx_a, idx_b, pa, pb;
  logic [P_W-1:0]       pp;
  logic                 plast, pclear, pstep;
  logic                 accept, ack_hit, timeout_hit;
  logic                 occ_r, to_r, ovr_r;

  pair_index_counter #(
    .NUM_BALLS (NUM_BALLS),
    .IDX_W     (IDX_W),
    .P_W       (P_W)
  ) u_pair_idx (
    .clk    (clk),
    .resetN (resetN),
    .clear  (pclear),
    .step   (pstep),
    .a      (pa),
    .b      (pb),
    .p      (pp),
    .last   (plast)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    pclear      = 1'b0;
    pstep       = 1'b0;
    accept      = 1'b0;
    ack_hit     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (bus.frameStart) begin
          accept    = 1'b1;
          pclear    = 1'b1;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (pending[pp]) begin
          state_nxt = ISSUE;
        end else begin
          pstep     = 1'b1;
          state_nxt = plast ? DONE : SCAN;
        end
      end
      ISSUE: begin
        // A late ack landing on the expiry cycle still counts as a resolution.
        if (bus.resolveAck) begin
          ack_hit   = 1'b1;
          pstep     = 1'b1;
          state_nxt = plast ? DONE : SCAN;
        end else if (wait_cnt == WAIT_W'(ACK_TIMEOUT)) begin
          timeout_hit = 1'b1;
          pstep       = 1'b1;
          state_nxt   = plast ? DONE : SCAN;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      armed    <= '1;
      pending  <= '0;
      wait_cnt <= '0;
      count    <= '0;
      idx_a    <= '0;
      idx_b    <= '0;
      occ_r    <= 1'b0;
      to_r     <= 1'b0;
      ovr_r    <= 1'b0;
    end else begin
      occ_r <= ack_hit;
      to_r  <= timeout_hit;
      ovr_r <= bus.frameStart && (state != IDLE);
      // A pair that touches now is disarmed; only a non-touching frame re-arms it.
      if (accept) begin
        pending <= bus.hitPairs & armed;
        armed   <= ~bus.hitPairs;
        count   <= '0;
      end
      if (ack_hit || timeout_hit) pending[pp] <= 1'b0;
      if (ack_hit && (count != 8'hFF)) count <= count + 8'd1;
      if (state == SCAN && pending[pp]) begin
        idx_a    <= pa;
        idx_b    <= pb;
        wait_cnt <= '0;
      end else if (state == ISSUE && !ack_hit && !timeout_hit) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
    end
  end

  // busy includes the accepting cycle so an empty sweep spans NUM_PAIRS+2 cycles.
  assign bus.busy              = (state != IDLE) || bus.frameStart;
  assign bus.resolveReq        = (state == ISSUE);
  assign bus.resolveIdxA       = idx_a;
  assign bus.resolveIdxB       = idx_b;
  assign bus.collisionOccurred = occ_r;
  assign bus.collisionCount    = count;
  assign bus.sweepOverrun      = ovr_r;
  assign bus.resolveTimeout    = to_r;

endmodule

// File: tb/tb_collision_pair_scheduler.sv
// Directed bench for collision_pair_scheduler with 4 balls (6 pairs) and a short ack timeout.
// Pairs: (0,1)=0 (0,2)=1 (0,3)=2 (1,2)=3 (1,3)=4 (2,3)=5.
module tb_collision_pair_scheduler;

  localparam int N  = 4;
  localparam int NP = 6;
  localparam int AT = 20;

  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  collision_pair_scheduler_if #(.NUM_BALLS(N)) sif ();

  collision_pair_scheduler #(
    .NUM_BALLS   (N),
    .ACK_TIMEOUT (AT)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (sif)
  );

  int compared = 0;
  int failed   = 0;

  int r_reqs, r_occ, r_to, r_ovr, r_busy, r_cnt, r_unstable, r_len;
  int a_q[$];
  int b_q[$];

  // Runs one frame: pulses frameStart, acks each request on its ack_delay-th
  // cycle (never if negative), optionally fires a second frameStart while busy.
  task automatic run_frame(input logic [NP-1:0] hits, input int ack_delay, input bit inject);
    int  wait_n;
    bit  done;
    int  la, lb;
    r_reqs = 0; r_occ = 0; r_to = 0; r_ovr = 0; r_busy = 0; r_unstable = 0; r_len = 0;
    a_q.delete(); b_q.delete();
    wait_n = 0; la = 0; lb = 0; done = 0;
    @(negedge clk);
    sif.hitPairs   = hits;
    sif.frameStart = 1'b1;
    #1;
    if (sif.busy) r_busy++;
    for (int cyc = 0; cyc < 500 && !done; cyc++) begin
      @(negedge clk);
      sif.frameStart = 1'b0;
      sif.resolveAck = 1'b0;
      #1;
      if (sif.collisionOccurred) r_occ++;
      if (sif.resolveTimeout)    r_to++;
      if (sif.sweepOverrun)      r_ovr++;
      if (!sif.busy) begin
        done = 1;
      end else begin
        r_busy++;
        if (sif.resolveReq) begin
          wait_n++;
          if (wait_n == 1) begin
            la = int'(sif.resolveIdxA);
            lb = int'(sif.resolveIdxB);
            a_q.push_back(la);
            b_q.push_back(lb);
            r_reqs++;
            if (inject) begin
              sif.frameStart = 1'b1;
              sif.hitPairs   = '1;
            end
          end else if (int'(sif.resolveIdxA) != la || int'(sif.resolveIdxB) != lb) begin
            r_unstable++;
          end
          if (r_reqs == 1) r_len = wait_n;
          if (wait_n == ack_delay) sif.resolveAck = 1'b1;
        end else begin
          wait_n = 0;
        end
      end
    end
    r_cnt = int'(sif.collisionCount);
    if (!done) begin
      compared++; failed++;
      $display("FAIL sweep_end: busy still %0d after 500 cycles, required 0", sif.busy);
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    sif.frameStart = 1'b0;
    sif.hitPairs   = '0;
    sif.resolveAck = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    compared++; if (sif.resolveReq !== 1'b0) begin failed++; $display("FAIL reset_req: got %b want 0", sif.resolveReq); end
    compared++; if (sif.busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %b want 0", sif.busy); end
    compared++; if (sif.collisionCount !== 8'd0) begin failed++; $display("FAIL reset_count: got %0d want 0", sif.collisionCount); end
    compared++; if (sif.resolveIdxA !== 2'd0 || sif.resolveIdxB !== 2'd0) begin failed++; $display("FAIL reset_idx: got %0d,%0d want 0,0", sif.resolveIdxA, sif.resolveIdxB); end
    compared++; if ({sif.collisionOccurred, sif.sweepOverrun, sif.resolveTimeout} !== 3'b000) begin failed++; $display("FAIL reset_pulses: got %b want 000", {sif.collisionOccurred, sif.sweepOverrun, sif.resolveTimeout}); end
    @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic test_empty_sweep();
    run_frame(6'b000000, 1, 0);
    compared++; if (r_reqs != 0) begin failed++; $display("FAIL empty_reqs: got %0d want 0", r_reqs); end
    compared++; if (r_busy != NP + 2) begin failed++; $display("FAIL empty_busy_cycles: got %0d want %0d", r_busy, NP + 2); end
    compared++; if (r_cnt != 0) begin failed++; $display("FAIL empty_count: got %0d want 0", r_cnt); end
  endtask

  task automatic test_single_hit();
    run_frame(6'b010000, 3, 0);
    compared++; if (r_reqs != 1) begin failed++; $display("FAIL single_reqs: got %0d want 1", r_reqs); end
    compared++; if (r_reqs > 0 && (a_q[0] != 1 || b_q[0] != 3)) begin failed++; $display("FAIL single_idx: got %0d,%0d want 1,3", a_q[0], b_q[0]); end
    compared++; if (r_len != 3) begin failed++; $display("FAIL single_req_len: got %0d want 3", r_len); end
    compared++; if (r_occ != 1) begin failed++; $display("FAIL single_occurred: got %0d want 1", r_occ); end
    compared++; if (r_cnt != 1) begin failed++; $display("FAIL single_count: got %0d want 1", r_cnt); end
    compared++; if (r_busy != NP + 2 + 3) begin failed++; $display("FAIL single_busy_cycles: got %0d want %0d", r_busy, NP + 5); end
  endtask

  task automatic test_rearm();
    for (int f = 0; f < 3; f++) begin
      run_frame(6'b010000, 1, 0);
      compared++; if (r_reqs != 0) begin failed++; $display("FAIL disarmed_reqs frame %0d: got %0d want 0", f, r_reqs); end
    end
    compared++; if (r_cnt != 0) begin failed++; $display("FAIL disarmed_count: got %0d want 0", r_cnt); end
    run_frame(6'b000000, 1, 0);
    compared++; if (r_reqs != 0) begin failed++; $display("FAIL rearm_clear_reqs: got %0d want 0", r_reqs); end
    run_frame(6'b010000, 2, 0);
    compared++; if (r_reqs != 1) begin failed++; $display("FAIL rearm_reqs: got %0d want 1", r_reqs); end
    compared++; if (r_reqs > 0 && (a_q[0] != 1 || b_q[0] != 3)) begin failed++; $display("FAIL rearm_idx: got %0d,%0d want 1,3", a_q[0], b_q[0]); end
  endtask

  task automatic test_back_to_back();
    run_frame(6'b100001, 2, 0);
    compared++; if (r_reqs != 2) begin failed++; $display("FAIL b2b_reqs: got %0d want 2", r_reqs); end
    compared++; if (r_reqs > 1 && (a_q[0] != 0 || b_q[0] != 1 || a_q[1] != 2 || b_q[1] != 3)) begin failed++; $display("FAIL b2b_order: got (%0d,%0d)(%0d,%0d) want (0,1)(2,3)", a_q[0], b_q[0], a_q[1], b_q[1]); end
    compared++; if (r_unstable != 0) begin failed++; $display("FAIL b2b_idx_stable: got %0d changes want 0", r_unstable); end
    compared++; if (r_cnt != 2 || r_occ != 2) begin failed++; $display("FAIL b2b_count: got count %0d pulses %0d want 2,2", r_cnt, r_occ); end
    compared++; if (r_busy != NP + 2 + 4) begin failed++; $display("FAIL b2b_busy_cycles: got %0d want %0d", r_busy, NP + 6); end
  endtask

  task automatic test_timeout();
    run_frame(6'b001000, -1, 0);
    compared++; if (r_reqs != 1 || (r_reqs > 0 && (a_q[0] != 1 || b_q[0] != 2))) begin failed++; $display("FAIL to_req: got %0d reqs want 1 at (1,2)", r_reqs); end
    compared++; if (r_to != 1) begin failed++; $display("FAIL to_pulse: got %0d want 1", r_to); end
    compared++; if (r_len != AT + 1) begin failed++; $display("FAIL to_req_len: got %0d want %0d", r_len, AT + 1); end
    compared++; if (r_occ != 0 || r_cnt != 0) begin failed++; $display("FAIL to_count: got pulses %0d count %0d want 0,0", r_occ, r_cnt); end
    compared++; if (r_busy != NP + 2 + AT + 1) begin failed++; $display("FAIL to_busy_cycles: got %0d want %0d", r_busy, NP + AT + 3); end
    run_frame(6'b001000, 1, 0);
    compared++; if (r_reqs != 0 || r_to != 0) begin failed++; $display("FAIL to_no_retry: got reqs %0d timeouts %0d want 0,0", r_reqs, r_to); end
    run_frame(6'b000000, 1, 0);
    run_frame(6'b001000, 1, 0);
    compared++; if (r_reqs != 1 || r_cnt != 1) begin failed++; $display("FAIL to_rearmed: got reqs %0d count %0d want 1,1", r_reqs, r_cnt); end
  endtask

  task automatic test_ack_at_timeout();
    run_frame(6'b000100, AT + 1, 0);
    compared++; if (r_reqs != 1 || (r_reqs > 0 && (a_q[0] != 0 || b_q[0] != 3))) begin failed++; $display("FAIL lateack_req: got %0d reqs want 1 at (0,3)", r_reqs); end
    compared++; if (r_to != 0) begin failed++; $display("FAIL lateack_timeout: got %0d want 0", r_to); end
    compared++; if (r_occ != 1 || r_cnt != 1) begin failed++; $display("FAIL lateack_count: got pulses %0d count %0d want 1,1", r_occ, r_cnt); end
  endtask

  task automatic test_overrun();
    run_frame(6'b000010, 5, 1);
    compared++; if (r_ovr != 1) begin failed++; $display("FAIL ovr_pulse: got %0d want 1", r_ovr); end
    compared++; if (r_reqs != 1 || (r_reqs > 0 && (a_q[0] != 0 || b_q[0] != 2))) begin failed++; $display("FAIL ovr_sweep: got %0d reqs want 1 at (0,2)", r_reqs); end
    compared++; if (r_cnt != 1 || r_occ != 1) begin failed++; $display("FAIL ovr_count: got count %0d pulses %0d want 1,1", r_cnt, r_occ); end
    run_frame(6'b100000, 1, 0);
    compared++; if (r_reqs != 1) begin failed++; $display("FAIL ovr_armed_kept: got %0d reqs want 1", r_reqs); end
  endtask

  task automatic test_reset_mid_issue();
    bit seen;
    @(negedge clk);
    sif.hitPairs   = 6'b000001;
    sif.frameStart = 1'b1;
    @(negedge clk);
    sif.frameStart = 1'b0;
    #1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (sif.resolveReq) seen = 1;
      else begin @(negedge clk); #1; end
    end
    compared++; if (!seen) begin failed++; $display("FAIL midrst_req_seen: got 0 want 1"); end
    #2;
    resetN = 1'b0;
    #1;
    compared++; if (sif.resolveReq !== 1'b0) begin failed++; $display("FAIL midrst_req_drop: got %b want 0", sif.resolveReq); end
    compared++; if (sif.busy !== 1'b0) begin failed++; $display("FAIL midrst_busy: got %b want 0", sif.busy); end
    @(negedge clk);
    resetN = 1'b1;
    run_frame(6'b100000, 1, 0);
    compared++; if (r_reqs != 1 || (r_reqs > 0 && (a_q[0] != 2 || b_q[0] != 3))) begin failed++; $display("FAIL midrst_armed: got %0d reqs want 1 at (2,3)", r_reqs); end
    compared++; if (r_cnt != 1) begin failed++; $display("FAIL midrst_count: got %0d want 1", r_cnt); end
  endtask

  initial begin
    test_reset();
    test_empty_sweep();
    test_single_hit();
    test_rearm();
    test_back_to_back();
    test_timeout();
    test_ack_at_timeout();
    test_overrun();
    test_reset_mid_issue();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
